// File: rtl/dm_bus_bridge_pkg.sv
// Shared encodings for the data-memory bus bridge.
package dm_bus_bridge_pkg;

  localparam int unsigned WORD_W = 32;

  // DataType encoding shared with the pipeline's MEM/WB stages.
  localparam logic [2:0] DT_WORD = 3'd0;
  localparam logic [2:0] DT_HALF = 3'd1;
  localparam logic [2:0] DT_BYTE = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dm_lane_pack.sv
// Alignment check, byte enables and lane-replicated write data for one access.
module dm_lane_pack
  import dm_bus_bridge_pkg::*;
(
  input  logic [2:0]        i_type,
  input  logic [1:0]        i_addr_lo,
  input  logic [WORD_W-1:0] i_wd,
  output logic              o_aligned,
  output logic [3:0]        o_be,
  output logic [WORD_W-1:0] o_wdata
);

  // Decode size; unknown types fall through to WORD.
  always_comb begin
    o_aligned = 1'b1;
    o_be      = 4'b1111;
    o_wdata   = i_wd;
    case (i_type)
      DT_HALF: begin
        o_aligned = ~i_addr_lo[0];
        o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_wd[15:0]}};
      end
      DT_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wd[7:0]}};
      end
      default: begin
        o_aligned = (i_addr_lo == 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dm_bus_bridge.sv
// MEM-stage to valid/ready bus bridge: one bus transaction per load/store,
// pipeline stalled until the bus answers or the access times out.
module dm_bus_bridge
  import dm_bus_bridge_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       TIMEOUT   = 16,
  parameter logic [WORD_W-1:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_type,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [WORD_W-1:0] i_req_wd,
  output logic [WORD_W-1:0] o_rd,
  output logic              o_stall,
  output logic              o_misalign,
  output logic              o_bus_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_be,
  output logic [WORD_W-1:0] o_bus_wdata,
  input  logic              i_bus_ready,
  input  logic [WORD_W-1:0] i_bus_rdata
);

  localparam int unsigned      CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e              r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic [WORD_W-1:0]   r_rd, w_rd_d;
  logic                r_bus_req, w_bus_req_d;
  logic                r_bus_we, w_bus_we_d;
  logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr_d;
  logic [3:0]          r_bus_be, w_bus_be_d;
  logic [WORD_W-1:0]   r_bus_wdata, w_bus_wdata_d;
  logic                r_misalign, w_misalign_d;
  logic                r_bus_err, w_bus_err_d;

  logic                w_aligned;
  logic [3:0]          w_be;
  logic [WORD_W-1:0]   w_wdata;

  dm_lane_pack u_lane_pack (
    .i_type    (i_req_type),
    .i_addr_lo (i_req_addr[1:0]),
    .i_wd      (i_req_wd),
    .o_aligned (w_aligned),
    .o_be      (w_be),
    .o_wdata   (w_wdata)
  );

  // Next-state and next-register values; pulses default low every cycle.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_rd_d        = r_rd;
    w_bus_req_d   = r_bus_req;
    w_bus_we_d    = r_bus_we;
    w_bus_addr_d  = r_bus_addr;
    w_bus_be_d    = r_bus_be;
    w_bus_wdata_d = r_bus_wdata;
    w_misalign_d  = 1'b0;
    w_bus_err_d   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (w_aligned) begin
            w_bus_req_d   = 1'b1;
            w_bus_we_d    = i_req_we;
            w_bus_addr_d  = {i_req_addr[ADDR_W-1:2], 2'b00};
            w_bus_be_d    = w_be;
            w_bus_wdata_d = w_wdata;
            w_cnt_d       = '0;
            w_state_d     = S_WAIT;
          end else begin
            w_misalign_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A ready on the final allowed cycle still wins over the timeout.
        if (i_bus_ready) begin
          if (!r_bus_we) w_rd_d = i_bus_rdata;
          w_bus_req_d = 1'b0;
          w_state_d   = S_DONE;
        end else if (r_cnt == CNT_MAX) begin
          w_rd_d      = ERR_RDATA;
          w_bus_err_d = 1'b1;
          w_bus_req_d = 1'b0;
          w_state_d   = S_DONE;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_d = S_IDLE;
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rd        <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_rd        <= w_rd_d;
      r_bus_req   <= w_bus_req_d;
      r_bus_we    <= w_bus_we_d;
      r_bus_addr  <= w_bus_addr_d;
      r_bus_be    <= w_bus_be_d;
      r_bus_wdata <= w_bus_wdata_d;
      r_misalign  <= w_misalign_d;
      r_bus_err   <= w_bus_err_d;
    end
  end

  // Stall until DONE; a dropped misaligned access never stalls.
  always_comb begin
    o_stall = i_req_valid & w_aligned & ((r_state == S_IDLE) | (r_state == S_WAIT));
  end

  assign o_rd        = r_rd;
  assign o_misalign  = r_misalign;
  assign o_bus_err   = r_bus_err;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_be    = r_bus_be;
  assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Randomized bench for dm_bus_bridge against a transaction-level model.
module tb_dm_bus_bridge;

  localparam int unsigned TO      = 4;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wd = 32'd0;
  logic [31:0] rd;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_rd = 32'd0;

  always #5 clk = ~clk;

  dm_bus_bridge #(
    .ADDR_W    (32),
    .TIMEOUT   (TO),
    .ERR_RDATA (ERR_VAL)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_req_type  (req_type),
    .i_req_addr  (req_addr),
    .i_req_wd    (req_wd),
    .o_rd        (rd),
    .o_stall     (stall),
    .o_misalign  (misalign),
    .o_bus_err   (bus_err),
    .o_bus_req   (bus_req),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_be    (bus_be),
    .o_bus_wdata (bus_wdata),
    .i_bus_ready (bus_ready),
    .i_bus_rdata (bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes; anything unknown is a word.
  function automatic int acc_size(input logic [2:0] ty);
    if (ty == 3'd1) return 2;
    if (ty == 3'd2) return 1;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input int sz, input logic [31:0] addr);
    int off = int'(addr % 4);
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] wd);
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (sz * 8)) - 32'd1);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < 4 / sz; i++) w = w | ((wd & mask) << (i * sz * 8));
    return w;
  endfunction

  // One MEM-stage access; bus answers after dly WAIT cycles (dly >= TO means never).
  task automatic run_txn(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                         input logic [31:0] wd, input int dly, input logic [31:0] rdat);
    int          sz = acc_size(ty);
    logic        al = (addr % sz) == 0;
    bit          timed_out = (dly > int'(TO) - 1);
    int          n_wait = timed_out ? int'(TO) : dly + 1;
    int          n_req = 0;
    int          n_stall = 0;
    req_valid = 1'b1; req_we = we; req_type = ty; req_addr = addr; req_wd = wd;
    bus_ready = 1'b0; bus_rdata = $urandom;
    #1;
    check_eq("idle_stall", 32'(stall), 32'(al));
    check_eq("idle_bus_req", 32'(bus_req), 32'd0);
    if (stall) n_stall++;
    next_cycle();
    if (!al) begin
      req_valid = 1'b0;
      #1;
      check_eq("misalign_pulse", 32'(misalign), 32'd1);
      check_eq("misalign_no_req", 32'(bus_req), 32'd0);
      check_eq("misalign_no_stall", 32'(stall), 32'd0);
      next_cycle();
      #1;
      check_eq("misalign_cleared", 32'(misalign), 32'd0);
      check_eq("misalign_still_no_req", 32'(bus_req), 32'd0);
      return;
    end
    for (int k = 0; k < int'(TO); k++) begin
      bus_ready = (k == dly);
      bus_rdata = (k == dly) ? rdat : $urandom;
      #1;
      check_eq("wait_bus_req", 32'(bus_req), 32'd1);
      check_eq("wait_bus_we", 32'(bus_we), 32'(we));
      check_eq("wait_bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
      check_eq("wait_bus_be", 32'(bus_be), 32'(model_be(sz, addr)));
      check_eq("wait_bus_wdata", bus_wdata, model_wdata(sz, wd));
      check_eq("wait_stall", 32'(stall), 32'd1);
      if (bus_req) n_req++;
      if (stall) n_stall++;
      next_cycle();
      if (k == dly) break;
    end
    bus_ready = 1'b0;
    bus_rdata = $urandom;
    if (timed_out) m_rd = ERR_VAL;
    else if (!we) m_rd = rdat;
    #1;
    check_eq("req_cycles", 32'(n_req), 32'(n_wait));
    check_eq("stall_cycles", 32'(n_stall), 32'(n_wait + 1));
    check_eq("done_stall", 32'(stall), 32'd0);
    check_eq("done_bus_req", 32'(bus_req), 32'd0);
    check_eq("done_bus_err", 32'(bus_err), 32'(timed_out));
    check_eq("done_rd", rd, m_rd);
    check_eq("done_misalign", 32'(misalign), 32'd0);
    next_cycle();
    req_valid = 1'b0;
    #1;
    check_eq("post_bus_err", 32'(bus_err), 32'd0);
    check_eq("post_bus_req", 32'(bus_req), 32'd0);
    check_eq("post_rd_hold", rd, m_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd", rd, 32'd0);
    check_eq("rst_bus_req", 32'(bus_req), 32'd0);
    check_eq("rst_bus_we", 32'(bus_we), 32'd0);
    check_eq("rst_bus_be", 32'(bus_be), 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'd0);
    check_eq("rst_bus_wdata", bus_wdata, 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    check_eq("rst_bus_err", 32'(bus_err), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    reset = 1'b1;
    next_cycle();

    run_txn(1'b1, 3'd0, 32'h0000_1004, 32'h1234_5678, 0, 32'h0);
    run_txn(1'b0, 3'd1, 32'h0000_1002, 32'h0, 2, 32'hAABB_CCDD);
    run_txn(1'b1, 3'd2, 32'h0000_1003, 32'h0000_00EE, 1, 32'h0);
    run_txn(1'b0, 3'd0, 32'h0000_1002, 32'h0, 0, 32'h0);
    run_txn(1'b0, 3'd0, 32'h0000_2000, 32'h0, 10, 32'h5555_AAAA);
    run_txn(1'b0, 3'd0, 32'h0000_2004, 32'h0, int'(TO) - 1, 32'h0BAD_F00D);

    // Reset in the second WAIT cycle.
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h0000_3000;
    bus_ready = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    check_eq("pre_rst_bus_req", 32'(bus_req), 32'd1);
    next_cycle();
    reset = 1'b1;
    #1;
    m_rd = 32'd0;
    check_eq("midrst_bus_req", 32'(bus_req), 32'd0);
    check_eq("midrst_rd", rd, 32'd0);
    check_eq("midrst_stall", 32'(stall), 32'd1);
    check_eq("midrst_bus_be", 32'(bus_be), 32'd0);
    check_eq("midrst_bus_err", 32'(bus_err), 32'd0);
    req_valid = 1'b0;
    next_cycle();
    #1;
    check_eq("midrst_no_err", 32'(bus_err), 32'd0);
    check_eq("midrst_no_misalign", 32'(misalign), 32'd0);
    check_eq("midrst_stays_idle", 32'(bus_req), 32'd0);

    for (int n = 0; n < 300; n++) begin
      logic [2:0] ty = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                   : 3'($urandom_range(0, 2));
      int gap = $urandom_range(0, 2);
      run_txn(1'($urandom), ty, $urandom, $urandom, $urandom_range(0, int'(TO) + 1), $urandom);
      for (int g = 0; g < gap; g++) next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_bus_bridge.md
Name: dm_bus_bridge

Overview:
- Sits directly downstream of the MEM pipeline stage, replacing the zero-wait data memory with a valid/ready external bus.
- Converts one load/store per MEM-stage instruction into a single bus transaction.
- Holds the pipeline via `stall` until the bus completes, and returns the raw 32-bit read word. Sign/zero extension stays in WB.
- Flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, width of the CPU and bus byte address.
- TIMEOUT, 16, number of WAIT cycles without `bus_ready` before the bridge aborts the access; must be ≥ 1.
- ERR_RDATA, 32'h0000_0000, value returned on `rd` when an access times out.

Ports:
- clk  in  1  rising-edge clock, shared with the MEM stage.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  MEM stage holds a load or store (MemtoRegM | MemWriteM).
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  access size; uses the shared DataType encoding.
- req_addr  in  ADDR_W  byte address (ALUResM).
- req_wd  in  32  store data, right-aligned.
- rd  out  32  raw word read from the bus, valid in the DONE cycle.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and the MEM stage.
- misalign  out  1  one-cycle pulse: misaligned access dropped.
- bus_err  out  1  one-cycle pulse: access timed out.
- bus_req  out  1  bus request valid.
- bus_we  out  1  bus write strobe.
- bus_addr  out  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated write data.
- bus_ready  in  1  bus accepts (write) or returns data (read) this cycle.
- bus_rdata  in  32  read data, sampled when bus_ready=1.

Behaviour:
- Reset (reset=0 at a clk edge) forces:
  - state IDLE, timeout count 0;
  - rd=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0;
  - misalign=0, bus_err=0.
  - A reset mid-transaction drops bus_req at that edge. No completion is reported.
- Alignment rules:
  - WORD: addr[1:0]==0.
  - HALF: addr[0]==0.
  - BYTE: always aligned.
- Byte enables and write data:
  - WORD: bus_be=4'b1111, bus_wdata=wd.
  - HALF: bus_be = addr[1] ? 4'b1100 : 4'b0011; bus_wdata={2{wd[15:0]}}.
  - BYTE: bus_be = 4'b0001<<addr[1:0]; bus_wdata={4{wd[7:0]}}.
  - Loads also drive bus_be. The bus may ignore it on reads.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - req_valid & aligned → register bus_* from the req_* inputs, go to WAIT. bus_req=1 from the next cycle.
  - req_valid & misaligned → misalign=1 next cycle. No bus access, no stall; stay in IDLE.
- WAIT:
  - bus_req=1; all bus_* outputs held constant.
  - bus_ready=1 → capture bus_rdata into rd (loads only; rd unchanged on stores), clear bus_req, go to DONE.
  - Otherwise the timeout count increments. When count reaches TIMEOUT-1 without bus_ready: rd=ERR_RDATA, bus_err=1 next cycle, clear bus_req, go to DONE.
  - bus_ready arriving in the same cycle as the timeout limit counts as success.
- DONE:
  - stall=0 for exactly one cycle so the pipeline advances. Always go to IDLE next cycle.
  - A back-to-back memory instruction is therefore seen in IDLE.
- stall (combinational):
  - stall = req_valid & aligned & (state==IDLE | state==WAIT).
  - A one-cycle-ready bus gives the sequence IDLE(stall) → WAIT(stall, ready) → DONE(no stall). That is 2 stall cycles per access.
- Latency: minimum 2 cycles from req_valid to DONE; maximum TIMEOUT+1.
- req_* inputs are not required to stay stable after IDLE; the bridge uses its registered copies.
- Invalid req_type values are treated as WORD.

Decomposition:
- Shared package (macro.vh):
  - DataType encodings DT_WORD=3'd0, DT_HALF=3'd1, DT_BYTE=3'd2;
  - state encodings S_IDLE/S_WAIT/S_DONE;
  - the `Word` width macro.
- One natural sub-module: dm_lane_pack (combinational). It computes aligned, bus_be and bus_wdata from type, addr[1:0] and wd.
- The FSM and counter remain in dm_bus_bridge.

Test Plan:
- Aligned store, WORD, addr=0x0000_1004, wd=0x1234_5678, bus_ready high on the first WAIT cycle:
  - bus_addr=0x1004, bus_be=1111, bus_wdata=0x12345678, bus_we=1;
  - stall high for 2 cycles, then low for 1 cycle.
- HALF load, addr=0x1002, bus_rdata=0xAABB_CCDD, bus_ready after 3 WAIT cycles:
  - bus_be=1100;
  - rd=0xAABBCCDD in DONE;
  - stall high for 4 cycles.
- BYTE store, addr=0x1003, wd=0x0000_00EE:
  - bus_be=1000, bus_wdata=0xEEEEEEEE.
- Misaligned WORD load at addr=0x1002:
  - misalign pulses 1 cycle;
  - bus_req never asserts;
  - stall stays 0.
- Timeout, TIMEOUT=4, bus_ready held 0:
  - bus_req high for 4 cycles;
  - then bus_err pulse, rd=ERR_RDATA, one DONE cycle, return to IDLE.
- reset=0 in the second WAIT cycle:
  - next edge: bus_req=0, stall follows req_valid from IDLE, rd=0;
  - no bus_err or misalign pulse.
